// File: rtl/debounced_counter_pkg.sv
// Shared constants and helpers for the debounced button counter.
// Covers channel indices, count modes, counter actions and prescaler sizing.
package debounced_counter_pkg;

   localparam int CH_UP  = 0;
   localparam int CH_DN  = 1;
   localparam int CH_CLR = 2;
   localparam int NUM_CH = 3;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   typedef enum logic [1:0] {
      ACT_NONE = 2'd0,
      ACT_CLR  = 2'd1,
      ACT_UP   = 2'd2,
      ACT_DN   = 2'd3
   } cnt_action_e;

   // Width of a counter running 0..clk_div-1; never narrower than one bit.
   function automatic int prescale_width(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

// File: rtl/db_filter.sv
// One button channel: 2-flop synchroniser, tick-sampled hysteresis debouncer,
// and a single-cycle press pulse on each debounced rising edge.
module db_filter #(
   parameter int DB_LEN = 7
) (
   input  logic MHz,
   input  logic rst_n,
   input  logic i_btn,
   input  logic i_tick,
   output logic o_db,
   output logic o_press
);

   logic [1:0]        r_sync;
   logic [DB_LEN-2:0] r_shreg;
   logic              r_db;
   logic              r_db_q;
   logic [DB_LEN-1:0] w_window;
   logic              w_db_nxt;

   // The window is the newest sample plus the retained history, i.e. the
   // DB_LEN most recent samples once this tick has shifted in.
   assign w_window = {r_shreg, r_sync[1]};

   // Hysteresis decision: only an all-ones or all-zeros window moves db.
   always_comb begin
      w_db_nxt = r_db;
      if (i_tick) begin
         if (&w_window) begin
            w_db_nxt = 1'b1;
         end else if (~|w_window) begin
            w_db_nxt = 1'b0;
         end else begin
            w_db_nxt = r_db;
         end
      end else begin
         w_db_nxt = r_db;
      end
   end

   // Synchroniser for the asynchronous raw button.
   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_btn};
      end
   end

   // Sample history advances on ticks only.
   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
      end else if (i_tick) begin
         r_shreg <= w_window[DB_LEN-2:0];
      end
   end

   // Debounced state and its one-cycle delayed copy for edge detection.
   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_db   <= 1'b0;
         r_db_q <= 1'b0;
      end else begin
         r_db   <= w_db_nxt;
         r_db_q <= r_db;
      end
   end

   assign o_db    = r_db;
   assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/debounced_counter.sv
// Debounced up/down/clear counter: shared sample-tick prescaler, three
// db_filter channels, prioritised wrap/saturate counter, wrap pulse and led.
module debounced_counter
   import debounced_counter_pkg::*;
#(
   parameter int CLK_DIV  = 5000,
   parameter int DB_LEN   = 7,
   parameter int WIDTH    = 3,
   parameter int MAX      = 7,
   parameter int SATURATE = 0
) (
   input  logic             MHz,
   input  logic             rst_n,
   input  logic             btn_up,
   input  logic             btn_dn,
   input  logic             btn_clr,
   output logic [WIDTH-1:0] counter,
   output logic             wrap,
   output logic             led
);

   localparam int               PW       = prescale_width(CLK_DIV);
   localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MAX);
   localparam bit               SAT_EN   = (SATURATE != MODE_WRAP);

   logic [PW-1:0]     r_prescale;
   logic              w_tick;
   logic [NUM_CH-1:0] w_btn;
   logic [NUM_CH-1:0] w_db;
   logic [NUM_CH-1:0] w_press;
   cnt_action_e       w_action;
   logic [WIDTH-1:0]  w_cnt_nxt;
   logic              w_wrap_nxt;
   logic [WIDTH-1:0]  r_counter;
   logic              r_wrap;
   logic              r_led;

   assign w_tick = (r_prescale == PRE_LAST);

   // Free-running sample prescaler, 0..CLK_DIV-1.
   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_prescale <= '0;
      end else if (w_tick) begin
         r_prescale <= '0;
      end else begin
         r_prescale <= r_prescale + PW'(1);
      end
   end

   assign w_btn[CH_UP]  = btn_up;
   assign w_btn[CH_DN]  = btn_dn;
   assign w_btn[CH_CLR] = btn_clr;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      db_filter #(
         .DB_LEN (DB_LEN)
      ) u_db_filter (
         .MHz     (MHz),
         .rst_n   (rst_n),
         .i_btn   (w_btn[g]),
         .i_tick  (w_tick),
         .o_db    (w_db[g]),
         .o_press (w_press[g])
      );
   end

   // Resolve same-cycle presses: clear wins, up+down cancel out.
   always_comb begin
      w_action = ACT_NONE;
      if (w_press[CH_CLR]) begin
         w_action = ACT_CLR;
      end else if (w_press[CH_UP] && w_press[CH_DN]) begin
         w_action = ACT_NONE;
      end else if (w_press[CH_UP]) begin
         w_action = ACT_UP;
      end else if (w_press[CH_DN]) begin
         w_action = ACT_DN;
      end else begin
         w_action = ACT_NONE;
      end
   end

   // Next count; terminal values are compared first so the range stays 0..MAX.
   always_comb begin
      w_cnt_nxt  = r_counter;
      w_wrap_nxt = 1'b0;
      case (w_action)
         ACT_CLR: begin
            w_cnt_nxt = '0;
         end
         ACT_UP: begin
            if (r_counter == CNT_MAX) begin
               if (SAT_EN) begin
                  w_cnt_nxt = r_counter;
               end else begin
                  w_cnt_nxt  = '0;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_counter + WIDTH'(1);
            end
         end
         ACT_DN: begin
            if (r_counter == '0) begin
               if (SAT_EN) begin
                  w_cnt_nxt = r_counter;
               end else begin
                  w_cnt_nxt  = CNT_MAX;
                  w_wrap_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = r_counter - WIDTH'(1);
            end
         end
         default: begin
            w_cnt_nxt = r_counter;
         end
      endcase
   end

   // Registered count, wrap pulse and led.
   always_ff @(posedge MHz or negedge rst_n) begin
      if (!rst_n) begin
         r_counter <= '0;
         r_wrap    <= 1'b0;
         r_led     <= 1'b0;
      end else begin
         r_counter <= w_cnt_nxt;
         r_wrap    <= w_wrap_nxt;
         r_led     <= |w_db;
      end
   end

   assign counter = r_counter;
   assign wrap    = r_wrap;
   assign led     = r_led;

endmodule

// File: tb/tb_debounced_counter.sv
// Directed bench: a wrap-mode and a saturate-mode counter share the buttons;
// a model pushes expectations to a scoreboard that is popped after each press.
module tb_debounced_counter;

   localparam int CLK_DIV = 4;
   localparam int DB_LEN  = 3;
   localparam int WIDTH   = 3;
   localparam int MAX_V   = 5;
   localparam int LAT_MIN = 2 + (DB_LEN - 1) * CLK_DIV + 1;
   localparam int LAT_MAX = 2 + DB_LEN * CLK_DIV + 1;

   logic             MHz = 1'b0;
   logic             rst_n;
   logic             btn_up, btn_dn, btn_clr;
   logic [WIDTH-1:0] counter_w, counter_s;
   logic             wrap_w, wrap_s, led_w, led_s;

   int n_vec = 0;
   int n_err = 0;
   int wrap_hits_w = 0;
   int wrap_hits_s = 0;

   logic [2:0] m_cnt_w = 3'd0;
   logic [2:0] m_cnt_s = 3'd0;
   int         m_wraps_w = 0;
   int         m_wraps_s = 0;

   typedef struct {
      string      tag;
      logic [2:0] cnt_w;
      logic [2:0] cnt_s;
      int         wraps_w;
      int         wraps_s;
   } exp_t;
   exp_t sb[$];

   always #5 MHz = ~MHz;

   debounced_counter #(
      .CLK_DIV(CLK_DIV), .DB_LEN(DB_LEN), .WIDTH(WIDTH), .MAX(MAX_V), .SATURATE(0)
   ) u_dut_wrap (
      .MHz(MHz), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
      .counter(counter_w), .wrap(wrap_w), .led(led_w)
   );

   debounced_counter #(
      .CLK_DIV(CLK_DIV), .DB_LEN(DB_LEN), .WIDTH(WIDTH), .MAX(MAX_V), .SATURATE(1)
   ) u_dut_sat (
      .MHz(MHz), .rst_n(rst_n), .btn_up(btn_up), .btn_dn(btn_dn), .btn_clr(btn_clr),
      .counter(counter_s), .wrap(wrap_s), .led(led_s)
   );

   // Count every cycle in which each wrap output is high.
   always @(posedge MHz) begin
      if (wrap_w === 1'b1) wrap_hits_w <= wrap_hits_w + 1;
      if (wrap_s === 1'b1) wrap_hits_s <= wrap_hits_s + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge MHz);
   endtask

   function automatic void model_step(input logic [2:0] c, input bit up, input bit dn,
                                      input bit clr, input bit sat,
                                      output logic [2:0] nc, output int w);
      nc = c;
      w  = 0;
      if (clr) nc = 3'd0;
      else if (up && dn) nc = c;
      else if (up) begin
         if (c == 3'(MAX_V)) begin
            if (!sat) begin nc = 3'd0; w = 1; end
         end else nc = c + 3'd1;
      end else if (dn) begin
         if (c == 3'd0) begin
            if (!sat) begin nc = 3'(MAX_V); w = 1; end
         end else nc = c - 3'd1;
      end
   endfunction

   task automatic model_press(input bit up, input bit dn, input bit clr);
      logic [2:0] n;
      int         w;
      model_step(m_cnt_w, up, dn, clr, 1'b0, n, w);
      m_cnt_w = n; m_wraps_w += w;
      model_step(m_cnt_s, up, dn, clr, 1'b1, n, w);
      m_cnt_s = n; m_wraps_s += w;
   endtask

   task automatic sb_push(input string tag);
      exp_t e;
      e.tag = tag; e.cnt_w = m_cnt_w; e.cnt_s = m_cnt_s;
      e.wraps_w = m_wraps_w; e.wraps_s = m_wraps_s;
      sb.push_back(e);
   endtask

   task automatic sb_pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_cnt_wrapmode"}, 32'(counter_w), 32'(e.cnt_w));
         check({e.tag, "_cnt_satmode"},  32'(counter_s), 32'(e.cnt_s));
         check({e.tag, "_wraps_wrapmode"}, 32'(wrap_hits_w), 32'(e.wraps_w));
         check({e.tag, "_wraps_satmode"},  32'(wrap_hits_s), 32'(e.wraps_s));
      end
   endtask

   task automatic do_press(input string tag, input bit up, input bit dn, input bit clr);
      model_press(up, dn, clr);
      sb_push(tag);
      btn_up = up; btn_dn = dn; btn_clr = clr;
      cycles(20);
      btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
      cycles(24);
      sb_pop_check();
   endtask

   initial begin
      int         lat;
      logic [8:0] pat;

      rst_n = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
      cycles(3);
      check("reset_cnt_wrapmode", 32'(counter_w), 32'd0);
      check("reset_wrap_wrapmode", 32'(wrap_w), 32'd0);
      check("reset_led_wrapmode", 32'(led_w), 32'd0);
      check("reset_cnt_satmode", 32'(counter_s), 32'd0);
      check("reset_wrap_satmode", 32'(wrap_s), 32'd0);
      check("reset_led_satmode", 32'(led_s), 32'd0);
      rst_n = 1'b1;
      cycles(2);

      // Short glitch: 6 cycles cover at most 2 ticks, fewer than DB_LEN.
      sb_push("glitch");
      btn_up = 1'b1;
      cycles(6);
      btn_up = 1'b0;
      cycles(30);
      sb_pop_check();
      check("glitch_led", 32'(led_w), 32'd0);

      do_press("dn_from0", 1'b0, 1'b1, 1'b0);
      do_press("up_back", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) do_press($sformatf("wrap_up%0d", i), 1'b1, 1'b0, 1'b0);

      do_press("clr", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) do_press($sformatf("to3_%0d", i), 1'b1, 1'b0, 1'b0);
      do_press("up_dn_same", 1'b1, 1'b1, 1'b0);
      do_press("clr_with_up", 1'b1, 1'b0, 1'b1);

      // Held button: measure press-to-count latency, then hold to 200 cycles.
      model_press(1'b1, 1'b0, 1'b0);
      sb_push("held_up");
      btn_up = 1'b1;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge MHz);
         if (lat == 0 && counter_w !== 3'd0) lat = n;
      end
      check("held_latency_in_window", 32'((lat >= LAT_MIN + 1) && (lat <= LAT_MAX + 1)), 32'd1);
      check("held_led_wrapmode", 32'(led_w), 32'd1);
      check("held_led_satmode", 32'(led_s), 32'd1);
      cycles(160);
      sb_pop_check();

      // Asynchronous reset in the middle of the hold.
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_cnt", 32'(counter_w), 32'd0);
      check("async_rst_led", 32'(led_w), 32'd0);
      check("async_rst_cnt_sat", 32'(counter_s), 32'd0);
      m_cnt_w = 3'd0; m_cnt_s = 3'd0;
      cycles(3);
      rst_n = 1'b1;
      cycles(5);
      check("post_rst_not_yet", 32'(counter_w), 32'd0);
      model_press(1'b1, 1'b0, 1'b0);
      sb_push("held_through_reset");
      cycles(40);
      sb_pop_check();
      btn_up = 1'b0;
      cycles(30);
      check("release_led", 32'(led_w), 32'd0);
      check("release_no_extra", 32'(counter_w), 32'd1);

      // Bouncy down edge, one value per tick period.
      pat = 9'b1_1110_1101;
      for (int i = 0; i < 7; i++) begin
         btn_dn = pat[i];
         cycles(CLK_DIV);
      end
      check("bounce_before_third_one", 32'(counter_w), 32'd1);
      model_press(1'b0, 1'b1, 1'b0);
      sb_push("bouncy_dn");
      for (int i = 7; i < 9; i++) begin
         btn_dn = pat[i];
         cycles(CLK_DIV);
      end
      sb_pop_check();
      cycles(20);
      btn_dn = 1'b0;
      cycles(30);
      check("bouncy_single_dec", 32'(counter_w), 32'd0);
      check("bouncy_single_dec_sat", 32'(counter_s), 32'd0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
